// File: rtl/i2c_burst_reader_if.sv
// Host-side request/response bundle of the I2C burst reader.
// The SCL/SDA pads stay as plain inout ports on the reader itself.
interface i2c_burst_reader_if #(
    parameter int MAX_BYTES = 16,
    parameter int CNT_W     = 5
);
    logic                   i_start;
    logic [6:0]             i_dev_addr;
    logic [7:0]             i_reg_addr;
    logic [CNT_W-1:0]       i_nbytes;
    logic [8*MAX_BYTES-1:0] o_rd_data;
    logic                   o_byte_valid;
    logic [CNT_W-1:0]       o_byte_idx;
    logic                   o_busy;
    logic                   o_done;
    logic                   o_nack;

    modport master (
        output i_start, i_dev_addr, i_reg_addr, i_nbytes,
        input  o_rd_data, o_byte_valid, o_byte_idx, o_busy, o_done, o_nack
    );

    modport slave (
        input  i_start, i_dev_addr, i_reg_addr, i_nbytes,
        output o_rd_data, o_byte_valid, o_byte_idx, o_busy, o_done, o_nack
    );
endinterface

// File: rtl/i2c_burst_reader.sv
// I2C master performing a register burst read: write reg pointer, repeated START,
// read N bytes. Open-drain pads, quarter-period bit timing with clock stretching.
module i2c_burst_reader #(
    parameter int CLK_DIV   = 32,
    parameter int MAX_BYTES = 16,
    parameter int CNT_W     = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    i2c_burst_reader_if.slave bus,
    inout  wire               io_scl,
    inout  wire               io_sda
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        IDLE, START, TX_BYTE, RX_ACK, RSTART, RX_BYTE, TX_ACK, STOP, DONE
    } state_t;

    state_t                     r_state, w_next;
    logic [DIV_W-1:0]           r_div;
    logic [1:0]                 r_q;
    logic [2:0]                 r_bit;
    logic [1:0]                 r_phase;
    logic [6:0]                 r_dev;
    logic [7:0]                 r_reg;
    logic [CNT_W-1:0]           r_nbytes;
    logic [CNT_W-1:0]           r_idx;
    logic [CNT_W-1:0]           r_byte_idx;
    logic [7:0]                 r_shift;
    logic                       r_ack_bit;
    logic                       r_nack;
    logic                       r_byte_valid;
    logic [MAX_BYTES-1:0][7:0]  r_rd_data;

    logic                       w_scl_low, w_sda_low, w_busy, w_done;
    logic                       w_scl_in, w_sda_in;
    logic                       w_accept, w_hold, w_qtick, w_bit_end;
    logic                       w_last, w_byte_end;
    logic [CNT_W-1:0]           w_n_clamp;
    logic [7:0]                 w_tx_byte;

    assign io_scl   = w_scl_low ? 1'b0 : 1'bz;
    assign io_sda   = w_sda_low ? 1'b0 : 1'bz;
    assign w_scl_in = io_scl;
    assign w_sda_in = io_sda;

    assign w_accept   = (r_state == IDLE) && bus.i_start;
    assign w_n_clamp  = (bus.i_nbytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : bus.i_nbytes;
    // A slave holding SCL low after we released it freezes the bit timing.
    assign w_hold     = !w_scl_low && !w_scl_in;
    assign w_qtick    = (r_div == DIV_W'(CLK_DIV - 1)) && !w_hold;
    assign w_bit_end  = w_qtick && (r_q == 2'd3);
    assign w_last     = (r_idx == r_nbytes - CNT_W'(1));
    assign w_byte_end = (r_state == RX_BYTE) && w_bit_end && (r_bit == 3'd0);

    always_comb begin
        case (r_phase)
            2'd0:    w_tx_byte = {r_dev, 1'b0};
            2'd1:    w_tx_byte = r_reg;
            default: w_tx_byte = {r_dev, 1'b1};
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.i_start) w_next = (w_n_clamp == '0) ? DONE : START;
            START:   if (w_bit_end) w_next = TX_BYTE;
            TX_BYTE: if (w_bit_end && r_bit == 3'd0) w_next = RX_ACK;
            RX_ACK: begin
                if (w_bit_end) begin
                    if (r_ack_bit)             w_next = STOP;
                    else if (r_phase == 2'd0) w_next = TX_BYTE;
                    else if (r_phase == 2'd1) w_next = RSTART;
                    else                      w_next = RX_BYTE;
                end
            end
            RSTART:  if (w_bit_end) w_next = TX_BYTE;
            RX_BYTE: if (w_bit_end && r_bit == 3'd0) w_next = TX_ACK;
            TX_ACK:  if (w_bit_end) w_next = w_last ? STOP : RX_BYTE;
            STOP:    if (w_bit_end) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_scl_low = 1'b0;
        w_sda_low = 1'b0;
        w_busy    = 1'b1;
        w_done    = 1'b0;
        case (r_state)
            IDLE:    w_busy = 1'b0;
            START:   w_sda_low = (r_q >= 2'd2);
            RSTART: begin
                w_scl_low = (r_q == 2'd0);
                w_sda_low = (r_q >= 2'd2);
            end
            TX_BYTE: begin
                w_scl_low = (r_q == 2'd0);
                w_sda_low = !w_tx_byte[r_bit];
            end
            RX_ACK, RX_BYTE: w_scl_low = (r_q == 2'd0);
            TX_ACK: begin
                w_scl_low = (r_q == 2'd0);
                w_sda_low = !w_last;
            end
            STOP: begin
                w_scl_low = (r_q == 2'd0);
                w_sda_low = (r_q <= 2'd1);
            end
            DONE: begin
                w_busy = 1'b0;
                w_done = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div        <= '0;
            r_q          <= 2'd0;
            r_bit        <= 3'd7;
            r_phase      <= 2'd0;
            r_dev        <= 7'd0;
            r_reg        <= 8'd0;
            r_nbytes     <= '0;
            r_idx        <= '0;
            r_byte_idx   <= '0;
            r_shift      <= 8'd0;
            r_ack_bit    <= 1'b0;
            r_nack       <= 1'b0;
            r_byte_valid <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_byte_valid <= w_byte_end;
            if (w_accept) begin
                r_dev    <= bus.i_dev_addr;
                r_reg    <= bus.i_reg_addr;
                r_nbytes <= w_n_clamp;
                r_idx    <= '0;
                r_bit    <= 3'd7;
                r_phase  <= 2'd0;
                r_nack   <= 1'b0;
            end
            if (r_state == IDLE || r_state == DONE) begin
                r_div <= '0;
                r_q   <= 2'd0;
            end else if (w_qtick) begin
                r_div <= '0;
                r_q   <= r_q + 2'd1;
            end else if (!w_hold) begin
                r_div <= r_div + DIV_W'(1);
            end
            if (w_qtick && r_q == 2'd2) begin
                if (r_state == RX_ACK)  r_ack_bit <= w_sda_in;
                if (r_state == RX_BYTE) r_shift   <= {r_shift[6:0], w_sda_in};
            end
            if (w_bit_end) begin
                // r_bit wraps 0 -> 7, ready for the next byte without a reload.
                if (r_state == TX_BYTE || r_state == RX_BYTE) r_bit <= r_bit - 3'd1;
                if (r_state == RX_ACK) begin
                    if (r_ack_bit) r_nack  <= 1'b1;
                    else           r_phase <= r_phase + 2'd1;
                end
                if (r_state == TX_ACK) r_idx <= r_idx + CNT_W'(1);
            end
            if (w_byte_end) begin
                r_byte_idx <= r_idx;
                for (int k = 0; k < MAX_BYTES; k++)
                    if (r_idx == CNT_W'(k)) r_rd_data[k] <= r_shift;
            end
        end
    end

    assign bus.o_rd_data    = r_rd_data;
    assign bus.o_byte_valid = r_byte_valid;
    assign bus.o_byte_idx   = r_byte_idx;
    assign bus.o_busy       = w_busy;
    assign bus.o_done       = w_done;
    assign bus.o_nack       = r_nack;
endmodule

// File: tb/tb_i2c_burst_reader.sv
// Directed bench for i2c_burst_reader with a cycle-sampled I2C slave model
// (address 0x1D, returns base+k for data byte k, optional NACK and SCL stretch).
module tb_i2c_burst_reader;
    localparam int CLK_DIV = 4;
    localparam int MAXB    = 16;
    localparam int CW      = 5;
    localparam int STRETCH = 100;

    logic clk = 1'b0;
    logic rst_n;
    wire  scl, sda;
    pullup (scl);
    pullup (sda);

    i2c_burst_reader_if #(.MAX_BYTES(MAXB), .CNT_W(CW)) bus ();

    i2c_burst_reader #(.CLK_DIV(CLK_DIV), .MAX_BYTES(MAXB), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .io_scl(scl), .io_sda(sda)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    localparam int SL_IDLE = 0, SL_RX = 1, SL_ACK = 2, SL_TX = 3, SL_MACK = 4;
    logic [7:0] sl_base = 8'hA0;
    logic       sl_nack_reg = 1'b0;
    logic       sl_stretch_en = 1'b0;
    logic       sl_scl_low, sl_sda_low, p_scl, p_sda, sl_rw, sl_mack_bit;
    int         sl_mode, sl_bitcnt, sl_byte_no, sl_str_cnt, sl_str_state, sl_str_t0;
    logic [7:0] sl_sh, sl_tx_idx, sl_reg;
    logic [7:0] w_sl_tx, w_sl_nx;
    int sl_start_cnt = 0, sl_stop_cnt = 0, sl_mack_cnt = 0, sl_mnack_cnt = 0, sl_str_period = 0;

    assign scl = sl_scl_low ? 1'b0 : 1'bz;
    assign sda = sl_sda_low ? 1'b0 : 1'bz;
    assign w_sl_tx = sl_base + sl_tx_idx;
    assign w_sl_nx = sl_base + sl_tx_idx + 8'd1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_scl_low <= 1'b0; sl_sda_low <= 1'b0; p_scl <= 1'b1; p_sda <= 1'b1;
            sl_mode <= SL_IDLE; sl_bitcnt <= 0; sl_byte_no <= 0; sl_str_cnt <= 0;
            sl_str_state <= 0; sl_rw <= 1'b0; sl_sh <= 8'h00; sl_tx_idx <= 8'h00;
            sl_mack_bit <= 1'b1;
        end else begin
            p_scl <= scl;
            p_sda <= sda;
            if (!sl_stretch_en) sl_str_state <= 0;
            if (sl_str_cnt != 0) begin
                sl_str_cnt <= sl_str_cnt - 1;
                if (sl_str_cnt == 1) sl_scl_low <= 1'b0;
            end
            if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda === 1'b0) begin
                sl_mode <= SL_RX; sl_bitcnt <= 0; sl_byte_no <= 0; sl_sda_low <= 1'b0;
                sl_start_cnt <= sl_start_cnt + 1;
            end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda === 1'b1) begin
                sl_mode <= SL_IDLE; sl_sda_low <= 1'b0;
                sl_stop_cnt <= sl_stop_cnt + 1;
            end else if (p_scl === 1'b0 && scl === 1'b1) begin
                if (sl_mode == SL_RX) begin
                    sl_sh <= {sl_sh[6:0], sda};
                    sl_bitcnt <= sl_bitcnt + 1;
                end else if (sl_mode == SL_TX) begin
                    sl_bitcnt <= sl_bitcnt + 1;
                end else if (sl_mode == SL_MACK) begin
                    sl_mack_bit <= sda;
                    if (sda === 1'b0) sl_mack_cnt <= sl_mack_cnt + 1;
                    else              sl_mnack_cnt <= sl_mnack_cnt + 1;
                end
            end else if (p_scl === 1'b1 && scl === 1'b0) begin
                if (sl_str_state == 1) begin
                    sl_str_period <= cyc - sl_str_t0;
                    sl_str_state  <= 2;
                end
                case (sl_mode)
                    SL_RX: if (sl_bitcnt == 8) begin
                        sl_byte_no <= sl_byte_no + 1;
                        if (sl_byte_no == 0 && sl_sh[7:1] == 7'h1D) begin
                            sl_rw <= sl_sh[0]; sl_sda_low <= 1'b1; sl_mode <= SL_ACK;
                        end else if (sl_byte_no == 1 && !sl_nack_reg) begin
                            sl_reg <= sl_sh; sl_sda_low <= 1'b1; sl_mode <= SL_ACK;
                        end else if (sl_byte_no >= 2) begin
                            sl_sda_low <= 1'b1; sl_mode <= SL_ACK;
                        end else begin
                            sl_mode <= SL_IDLE;
                        end
                    end
                    SL_ACK: begin
                        sl_bitcnt <= 0;
                        if (sl_rw && sl_byte_no == 1) begin
                            sl_tx_idx <= 8'h00; sl_sda_low <= !sl_base[7]; sl_mode <= SL_TX;
                        end else begin
                            sl_sda_low <= 1'b0; sl_mode <= SL_RX;
                        end
                    end
                    SL_TX: begin
                        if (sl_bitcnt == 8) begin
                            sl_sda_low <= 1'b0; sl_mode <= SL_MACK;
                        end else begin
                            sl_sda_low <= !w_sl_tx[3'(7 - sl_bitcnt)];
                        end
                        // Hold SCL so the master sees it low for exactly STRETCH
                        // cycles after releasing it at the end of its low quarter.
                        if (sl_stretch_en && sl_str_state == 0 && sl_bitcnt == 3 && sl_tx_idx == 8'd2) begin
                            sl_scl_low <= 1'b1; sl_str_cnt <= CLK_DIV + STRETCH - 1;
                            sl_str_state <= 1; sl_str_t0 <= cyc;
                        end
                    end
                    SL_MACK: begin
                        if (sl_mack_bit === 1'b0) begin
                            sl_tx_idx <= sl_tx_idx + 8'd1; sl_bitcnt <= 0;
                            sl_sda_low <= !w_sl_nx[7]; sl_mode <= SL_TX;
                        end else begin
                            sl_sda_low <= 1'b0; sl_mode <= SL_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- output monitor ----------------
    int bv_cnt = 0, idx_err = 0, done_cnt = 0, low_cnt = 0;
    logic [CW-1:0] mon_idx = '0;
    always @(negedge clk) begin
        if (bus.o_byte_valid) begin
            if (bus.o_byte_idx !== mon_idx) idx_err <= idx_err + 1;
            bv_cnt <= bv_cnt + 1;
        end
        if (bus.o_done || !rst_n)   mon_idx <= '0;
        else if (bus.o_byte_valid)  mon_idx <= mon_idx + CW'(1);
        if (bus.o_done) done_cnt <= done_cnt + 1;
        if (scl === 1'b0 || sda === 1'b0) low_cnt <= low_cnt + 1;
    end

    // ---------------- checking helpers ----------------
    logic [7:0] exp_mem [MAXB];
    int d_snap, b_snap, i_snap, s_snap, a_snap, n_snap, l_snap;

    function automatic logic [8*MAXB-1:0] exp_vec();
        logic [8*MAXB-1:0] v;
        for (int k = 0; k < MAXB; k++) v[8*k +: 8] = exp_mem[k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        d_snap = done_cnt; b_snap = bv_cnt; i_snap = idx_err; s_snap = sl_stop_cnt;
        a_snap = sl_mack_cnt; n_snap = sl_mnack_cnt; l_snap = low_cnt;
    endtask

    task automatic start_txn(input logic [CW-1:0] n);
        bus.i_nbytes = n;
        bus.i_start  = 1'b1;
        @(negedge clk);
        bus.i_start  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (done_cnt == d_snap && i < 8000) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_done_seen"}, done_cnt != d_snap, 1);
        repeat (40) @(negedge clk);
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) exp_mem[k] = base + 8'(k);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_start = 1'b0; bus.i_dev_addr = 7'h1D; bus.i_reg_addr = 8'h06; bus.i_nbytes = '0;
        for (int k = 0; k < MAXB; k++) exp_mem[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_rd_data", bus.o_rd_data, 0);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_nack", bus.o_nack, 0);
        chk("rst_bvalid", bus.o_byte_valid, 0);
        chk("rst_bidx", bus.o_byte_idx, 0);
        chk("rst_lines", {scl, sda}, 2'b11);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 11-byte burst from reg 0x06
        sl_base = 8'hA0;
        snap();
        start_txn(5'd11);
        chk("t1_busy_rise", bus.o_busy, 1);
        wait_done("t1");
        fill(11, 8'hA0);
        chk("t1_rd_data", bus.o_rd_data, exp_vec());
        chk("t1_bv_count", bv_cnt - b_snap, 11);
        chk("t1_idx_seq", idx_err - i_snap, 0);
        chk("t1_master_acks", sl_mack_cnt - a_snap, 10);
        chk("t1_master_nacks", sl_mnack_cnt - n_snap, 1);
        chk("t1_stops", sl_stop_cnt - s_snap, 1);
        chk("t1_single_done", done_cnt - d_snap, 1);
        chk("t1_nack", bus.o_nack, 0);
        chk("t1_reg_seen", sl_reg, 8'h06);
        chk("t1_busy_fall", bus.o_busy, 0);

        // slave NACKs the register byte
        sl_nack_reg = 1'b1;
        snap();
        start_txn(5'd4);
        wait_done("t2");
        chk("t2_nack", bus.o_nack, 1);
        chk("t2_bv_count", bv_cnt - b_snap, 0);
        chk("t2_stops", sl_stop_cnt - s_snap, 1);
        chk("t2_rd_data_kept", bus.o_rd_data, exp_vec());
        sl_nack_reg = 1'b0;

        // zero-length request: immediate done, bus untouched, nack cleared
        snap();
        start_txn(5'd0);
        chk("t3_done_1cyc", bus.o_done, 1);
        chk("t3_busy", bus.o_busy, 0);
        chk("t3_nack_clear", bus.o_nack, 0);
        repeat (40) @(negedge clk);
        chk("t3_no_bus_low", low_cnt - l_snap, 0);
        chk("t3_single_done", done_cnt - d_snap, 1);

        // over-long request clamps to MAX_BYTES
        sl_base = 8'h50;
        snap();
        start_txn(5'd20);
        wait_done("t4");
        fill(16, 8'h50);
        chk("t4_bv_count", bv_cnt - b_snap, 16);
        chk("t4_master_nacks", sl_mnack_cnt - n_snap, 1);
        chk("t4_rd_data", bus.o_rd_data, exp_vec());

        // clock stretch on bit 3 of byte 2
        sl_base = 8'hC0; sl_stretch_en = 1'b1;
        snap();
        start_txn(5'd4);
        wait_done("t5");
        fill(4, 8'hC0);
        chk("t5_scl_period", sl_str_period, 4 * CLK_DIV + STRETCH);
        chk("t5_rd_data", bus.o_rd_data, exp_vec());
        sl_stretch_en = 1'b0;

        // start and input changes while busy are ignored
        sl_base = 8'h10;
        snap();
        start_txn(5'd3);
        repeat (20) @(negedge clk);
        bus.i_dev_addr = 7'h2A; bus.i_reg_addr = 8'h99;
        start_txn(5'd9);
        wait_done("t6");
        repeat (300) @(negedge clk);
        fill(3, 8'h10);
        chk("t6_bv_count", bv_cnt - b_snap, 3);
        chk("t6_single_done", done_cnt - d_snap, 1);
        chk("t6_reg_seen", sl_reg, 8'h06);
        chk("t6_busy_idle", bus.o_busy, 0);
        chk("t6_rd_data", bus.o_rd_data, exp_vec());
        bus.i_dev_addr = 7'h1D; bus.i_reg_addr = 8'h06;

        // reset in the middle of byte 5, then a fresh 2-byte read
        sl_base = 8'h70;
        snap();
        start_txn(5'd8);
        begin
            int i = 0;
            while (bv_cnt - b_snap < 5 && i < 8000) begin
                @(negedge clk);
                i++;
            end
        end
        chk("t7_reached_byte5", bv_cnt - b_snap, 5);
        repeat (60) @(negedge clk);
        chk("t7_busy_before_rst", bus.o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t7_lines_released", {scl, sda}, 2'b11);
        chk("t7_rd_data", bus.o_rd_data, 0);
        chk("t7_outs", {bus.o_busy, bus.o_done, bus.o_nack, bus.o_byte_valid, bus.o_byte_idx}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < MAXB; k++) exp_mem[k] = 8'h00;
        sl_base = 8'h33;
        snap();
        start_txn(5'd2);
        wait_done("t8");
        fill(2, 8'h33);
        chk("t8_bv_count", bv_cnt - b_snap, 2);
        chk("t8_rd_data", bus.o_rd_data, exp_vec());
        chk("t8_nack", bus.o_nack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
